// File: rtl/cpu_status_unit_pkg.sv
// Shared CPU definitions: status/flag bit positions, reset values and the
// saved-context type pushed on interrupt entry.
package cpu_status_unit_pkg;

    localparam int CPU_STATUS_W = 8;
    localparam int CPU_FLAGS_W  = 4;

    localparam int ST_DMA_ACK         = 0;
    localparam int ST_IRQ_EN          = 1;
    localparam int ST_MODE            = 2;
    localparam int ST_PAGING_EN       = 3;
    localparam int ST_HALT            = 4;
    localparam int ST_DISPLAYREG_LOAD = 5;
    localparam int ST_DIR             = 7;

    localparam int FL_ZF = 0;
    localparam int FL_CF = 1;
    localparam int FL_SF = 2;
    localparam int FL_OF = 3;

    localparam logic [CPU_STATUS_W-1:0] CPU_STATUS_RST = '0;
    localparam logic [CPU_FLAGS_W-1:0]  CPU_FLAGS_RST  = '0;

    // Handlers start in supervisor mode, interrupts off, paging off, running.
    localparam logic [CPU_STATUS_W-1:0] ENTER_CLR_MASK =
        CPU_STATUS_W'((1 << ST_IRQ_EN) | (1 << ST_MODE) |
                      (1 << ST_PAGING_EN) | (1 << ST_HALT));

    typedef struct packed {
        logic [CPU_STATUS_W-1:0] status;
        logic [CPU_FLAGS_W-1:0]  flags;
    } cpu_ctx_t;

endpackage

// File: rtl/cpu_ctx_stack.sv
// Generic LIFO of saved CPU contexts; push wins over pop, and both are
// ignored when they would overflow or underflow.
module cpu_ctx_stack
    import cpu_status_unit_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               push,
    input  logic               pop,
    input  cpu_ctx_t           push_data,
    output cpu_ctx_t           top_data,
    output logic [LEVEL_W-1:0] level,
    output logic               full,
    output logic               empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cpu_ctx_t       mem [0:DEPTH-1];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == LEVEL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !push && !empty;
    assign wr_ptr  = AW'(level);
    assign rd_ptr  = AW'(level - LEVEL_W'(1));
    assign top_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            level <= '0;
        end else if (do_push) begin
            level <= level + LEVEL_W'(1);
        end else if (do_pop) begin
            level <= level - LEVEL_W'(1);
        end
    end

    // Entry storage needs no reset; level alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/cpu_status_unit.sv
// CPU status byte and ALU flags with masked writes and interrupt context save.
// Define CPU_STATUS_STACK_EN for a STACK_DEPTH-deep LIFO; otherwise one shadow register.
module cpu_status_unit
    import cpu_status_unit_pkg::*;
#(
    parameter int STATUS_W    = CPU_STATUS_W,
    parameter int FLAGS_W     = CPU_FLAGS_W,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               arst_n,
    input  logic                               status_wr_en,
    input  logic [STATUS_W-1:0]                status_wr_mask,
    input  logic [STATUS_W-1:0]                status_wr_data,
    input  logic                               flags_wr_en,
    input  logic [FLAGS_W-1:0]                 flags_wr_mask,
    input  logic [FLAGS_W-1:0]                 flags_wr_data,
    input  logic                               irq_enter,
    input  logic                               irq_return,
    input  logic                               err_clr,
    output logic [STATUS_W-1:0]                status,
    output logic [FLAGS_W-1:0]                 flags,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               err_ovf,
    output logic                               err_unf
);

    localparam int LEVEL_W = $clog2(STACK_DEPTH + 1);

    cpu_ctx_t push_ctx;
    cpu_ctx_t top_ctx;

    assign push_ctx = '{status: status, flags: flags};

`ifdef CPU_STATUS_STACK_EN
    cpu_ctx_stack #(
        .DEPTH   (STACK_DEPTH),
        .LEVEL_W (LEVEL_W)
    ) u_stack (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (irq_enter),
        .pop       (irq_return),
        .push_data (push_ctx),
        .top_data  (top_ctx),
        .level     (stack_level),
        .full      (stack_full),
        .empty     (stack_empty)
    );
`else
    cpu_ctx_t shadow_ctx;
    logic     shadow_valid;

    // Single-entry save: a nested enter must not overwrite the first context.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            shadow_valid <= 1'b0;
            shadow_ctx   <= '{status: CPU_STATUS_RST, flags: CPU_FLAGS_RST};
        end else if (irq_enter) begin
            if (!shadow_valid) begin
                shadow_valid <= 1'b1;
                shadow_ctx   <= push_ctx;
            end
        end else if (irq_return) begin
            shadow_valid <= 1'b0;
        end
    end

    assign top_ctx     = shadow_ctx;
    assign stack_full  = shadow_valid;
    assign stack_empty = !shadow_valid;
    assign stack_level = LEVEL_W'(shadow_valid);
`endif

    // Clearing comes first so an error raised in the same cycle overrides it.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            status  <= CPU_STATUS_RST;
            flags   <= CPU_FLAGS_RST;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (err_clr) begin
                err_ovf <= 1'b0;
                err_unf <= 1'b0;
            end
            if (irq_enter) begin
                status <= status & ~ENTER_CLR_MASK;
                if (stack_full) begin
                    err_ovf <= 1'b1;
                end
            end else if (irq_return) begin
                if (stack_empty) begin
                    err_unf <= 1'b1;
                end else begin
                    status <= top_ctx.status;
                    flags  <= top_ctx.flags;
                end
            end else begin
                if (status_wr_en) begin
                    status <= (status & ~status_wr_mask) | (status_wr_data & status_wr_mask);
                end
                if (flags_wr_en) begin
                    flags <= (flags & ~flags_wr_mask) | (flags_wr_data & flags_wr_mask);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_status_unit.sv
// Directed bench for cpu_status_unit; expectations follow CPU_STATUS_STACK_EN.
module tb_cpu_status_unit;

`ifdef CPU_STATUS_STACK_EN
    localparam int DEPTH_EFF = 4;
`else
    localparam int DEPTH_EFF = 1;
`endif

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       status_wr_en = 1'b0;
    logic [7:0] status_wr_mask = '0;
    logic [7:0] status_wr_data = '0;
    logic       flags_wr_en = 1'b0;
    logic [3:0] flags_wr_mask = '0;
    logic [3:0] flags_wr_data = '0;
    logic       irq_enter = 1'b0;
    logic       irq_return = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] status;
    logic [3:0] flags;
    logic [2:0] stack_level;
    logic       stack_full;
    logic       stack_empty;
    logic       err_ovf;
    logic       err_unf;

    int checks = 0;
    int errors = 0;

    logic [7:0] ctx_s [5] = '{8'h21, 8'h42, 8'h63, 8'h84, 8'hA5};
    logic [3:0] ctx_f [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF};

    cpu_status_unit #(
        .STATUS_W    (8),
        .FLAGS_W     (4),
        .STACK_DEPTH (4)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .status_wr_en   (status_wr_en),
        .status_wr_mask (status_wr_mask),
        .status_wr_data (status_wr_data),
        .flags_wr_en    (flags_wr_en),
        .flags_wr_mask  (flags_wr_mask),
        .flags_wr_data  (flags_wr_data),
        .irq_enter      (irq_enter),
        .irq_return     (irq_return),
        .err_clr        (err_clr),
        .status         (status),
        .flags          (flags),
        .stack_level    (stack_level),
        .stack_full     (stack_full),
        .stack_empty    (stack_empty),
        .err_ovf        (err_ovf),
        .err_unf        (err_unf)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of inputs, samples 1 time unit after the edge, then idles.
    task automatic apply_stimulus(input logic s_en, input logic [7:0] s_mask, input logic [7:0] s_data,
                                  input logic f_en, input logic [3:0] f_mask, input logic [3:0] f_data,
                                  input logic enter, input logic ret, input logic clr);
        status_wr_en   = s_en;
        status_wr_mask = s_mask;
        status_wr_data = s_data;
        flags_wr_en    = f_en;
        flags_wr_mask  = f_mask;
        flags_wr_data  = f_data;
        irq_enter      = enter;
        irq_return     = ret;
        err_clr        = clr;
        @(posedge clk);
        #1;
        status_wr_en = 1'b0;
        flags_wr_en  = 1'b0;
        irq_enter    = 1'b0;
        irq_return   = 1'b0;
        err_clr      = 1'b0;
    endtask

    task automatic write_ctx(input logic [7:0] s, input logic [3:0] f);
        apply_stimulus(1'b1, 8'hFF, s, 1'b1, 4'hF, f, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse(input logic enter, input logic ret, input logic clr);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0, enter, ret, clr);
    endtask

    initial begin
        int pre;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_status", 32'(status), 32'h00);
        check_output("rst_flags", 32'(flags), 32'h0);
        check_output("rst_level", 32'(stack_level), 0);
        check_output("rst_empty", 32'(stack_empty), 1);
        check_output("rst_errs", 32'({err_ovf, err_unf}), 0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus(1'b1, 8'h0A, 8'hFF, 1'b1, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0);
        check_output("mask_status", 32'(status), 32'h0A);
        check_output("mask_flags", 32'(flags), 32'h5);
        apply_stimulus(1'b0, 8'hFF, 8'hFF, 1'b1, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0);
        check_output("flags_only_flags", 32'(flags), 32'h1);
        check_output("flags_only_status", 32'(status), 32'h0A);

        write_ctx(8'h1E, 4'h3);
        pulse(1'b1, 1'b0, 1'b0);
        check_output("enter_status", 32'(status), 32'h00);
        check_output("enter_flags", 32'(flags), 32'h3);
        check_output("enter_level", 32'(stack_level), 1);
        pulse(1'b0, 1'b1, 1'b0);
        check_output("ret_status", 32'(status), 32'h1E);
        check_output("ret_flags", 32'(flags), 32'h3);
        check_output("ret_level", 32'(stack_level), 0);

        for (int i = 0; i < 5; i++) begin
            write_ctx(ctx_s[i], ctx_f[i]);
            pulse(1'b1, 1'b0, 1'b0);
        end
        check_output("ovf_level", 32'(stack_level), DEPTH_EFF);
        check_output("ovf_full", 32'(stack_full), 1);
        check_output("ovf_err", 32'(err_ovf), 1);
        check_output("ovf_status", 32'(status), 32'hA1);
        for (int k = DEPTH_EFF - 1; k >= 0; k--) begin
            pulse(1'b0, 1'b1, 1'b0);
            check_output("pop_status", 32'(status), 32'(ctx_s[k]));
            check_output("pop_flags", 32'(flags), 32'(ctx_f[k]));
            check_output("pop_level", 32'(stack_level), k);
        end
        check_output("pop_unf_clear", 32'(err_unf), 0);
        pulse(1'b0, 1'b1, 1'b0);
        check_output("unf_err", 32'(err_unf), 1);
        check_output("unf_status", 32'(status), 32'h21);
        check_output("unf_empty", 32'(stack_empty), 1);

        pulse(1'b0, 1'b1, 1'b1);
        check_output("clr_vs_set_unf", 32'(err_unf), 1);
        check_output("clr_vs_set_ovf", 32'(err_ovf), 0);
        pulse(1'b0, 1'b0, 1'b1);
        check_output("clr_errs", 32'({err_ovf, err_unf}), 0);

        write_ctx(8'hBF, 4'hA);
        apply_stimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
        check_output("enter_wr_status", 32'(status), 32'hA1);
        check_output("enter_wr_flags", 32'(flags), 32'hA);
        check_output("enter_wr_level", 32'(stack_level), 1);
        apply_stimulus(1'b1, 8'hFF, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        check_output("ret_wr_status", 32'(status), 32'hBF);
        check_output("ret_wr_level", 32'(stack_level), 0);

        pre = (DEPTH_EFF > 1) ? 2 : 0;
        for (int i = 0; i < pre; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
        end
        check_output("pre_level", 32'(stack_level), pre);
        pulse(1'b1, 1'b1, 1'b0);
        check_output("both_level", 32'(stack_level), pre + 1);
        check_output("both_errs", 32'({err_ovf, err_unf}), 0);
        check_output("both_status", 32'(status), 32'hA1);

        for (int i = 0; i < DEPTH_EFF - pre; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
        end
        check_output("pre_rst_ovf", 32'(err_ovf), 1);
        check_output("pre_rst_level", 32'(stack_level), DEPTH_EFF);

        #2 arst_n = 1'b0;
        #1;
        check_output("async_status", 32'(status), 32'h00);
        check_output("async_flags", 32'(flags), 32'h0);
        check_output("async_level", 32'(stack_level), 0);
        check_output("async_errs", 32'({err_ovf, err_unf}), 0);
        check_output("async_empty", 32'(stack_empty), 1);
        @(posedge clk);
        #2 arst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("post_rst_status", 32'(status), 32'h00);
        check_output("post_rst_full", 32'(stack_full), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
